// File: rtl/serial_compare_lsb.sv
// Serial unsigned magnitude comparator: one 2-bit slice per clock, LSB slice first.
// Later (more significant) differing slices override earlier decisions.
module serial_compare_lsb #(
    parameter int unsigned S = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [S-1:0] A,
    input  logic [S-1:0] B,
    output logic         busy,
    output logic         done,
    output logic         EQ,
    output logic         LT
);

    localparam int unsigned NSLICE = S / 2;
    localparam int unsigned CW     = $clog2(NSLICE + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [S-1:0]  sa_q, sb_q;
    logic [CW-1:0] cnt_q;
    logic          req_q, rlt_q, req_d, rlt_d;
    logic          busy_q, done_q, eq_q, lt_q;
    logic [1:0]    slice_a, slice_b;

    // Fold the current slice into the running flags.
    always_comb begin
        slice_a = sa_q[1:0];
        slice_b = sb_q[1:0];
        req_d   = req_q;
        rlt_d   = rlt_q;
        if (slice_a != slice_b) begin
            req_d = 1'b0;
            rlt_d = (slice_a < slice_b);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            rlt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= A;
                        sb_q    <= B;
                        req_q   <= 1'b1;
                        rlt_q   <= 1'b0;
                        cnt_q   <= CW'(NSLICE);
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    sa_q  <= sa_q >> 2;
                    sb_q  <= sb_q >> 2;
                    cnt_q <= cnt_q - CW'(1);
                    req_q <= req_d;
                    rlt_q <= rlt_d;
                    if (cnt_q == CW'(1)) begin
                        eq_q    <= req_d;
                        lt_q    <= rlt_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign EQ   = eq_q;
    assign LT   = lt_q;

endmodule

// File: tb/tb_serial_compare_lsb.sv
// Randomized self-checking bench for serial_compare_lsb (S=8 and S=2 instances).
module tb_serial_compare_lsb;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, busy, done, eq, lt;
    logic [7:0] a, b;
    logic       start2, busy2, done2, eq2, lt2;
    logic [1:0] a2, b2;

    int checks = 0;
    int errors = 0;
    logic prev_eq = 1'b0, prev_lt = 1'b0;

    always #5 clk = ~clk;

    serial_compare_lsb #(.S(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
        .busy(busy), .done(done), .EQ(eq), .LT(lt)
    );

    serial_compare_lsb #(.S(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .EQ(eq2), .LT(lt2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // EQ and LT must never both be set.
    always @(negedge clk) begin
        if (!rst) begin
            chk("excl8", 32'(eq & lt), 32'd0);
            chk("busydone8", 32'(busy & done), 32'd0);
        end
    end

    // Called at a negedge with the DUT in IDLE or DONE; returns at the DONE negedge.
    task automatic op(input logic [7:0] va, input logic [7:0] vb, input bit noise);
        logic exp_eq, exp_lt;
        exp_eq = (va == vb);
        exp_lt = (va < vb);
        start = 1'b1;
        a = va;
        b = vb;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_eq_hold", 32'(eq), 32'(prev_eq));
            chk("run_lt_hold", 32'(lt), 32'(prev_lt));
            if (noise) begin
                start = 1'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("done", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("eq", 32'(eq), 32'(exp_eq));
        chk("lt", 32'(lt), 32'(exp_lt));
        prev_eq = exp_eq;
        prev_lt = exp_lt;
        start = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_eq", 32'(eq), 32'(prev_eq));
            chk("idle_lt", 32'(lt), 32'(prev_lt));
        end
    endtask

    task automatic op2(input logic [1:0] va, input logic [1:0] vb);
        start2 = 1'b1;
        a2 = va;
        b2 = vb;
        @(negedge clk);
        chk("s2_busy", 32'(busy2), 32'd1);
        chk("s2_run_done", 32'(done2), 32'd0);
        start2 = 1'b0;
        a2 = 2'($urandom);
        b2 = 2'($urandom);
        @(negedge clk);
        chk("s2_done", 32'(done2), 32'd1);
        chk("s2_eq", 32'(eq2), 32'(va == vb));
        chk("s2_lt", 32'(lt2), 32'(va < vb));
        @(negedge clk);
        chk("s2_done_clr", 32'(done2), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_eq", 32'(eq), 32'd0);
        chk("rst_lt", 32'(lt), 32'd0);
        rst = 1'b0;
        idle_check(2);

        // Directed cases
        op(8'h5A, 8'h5A, 1'b0); idle_check(1);
        op(8'h80, 8'h7F, 1'b0); idle_check(1);
        op(8'h01, 8'h02, 1'b0); idle_check(1);
        op(8'h00, 8'hFF, 1'b0); idle_check(1);
        op(8'hFF, 8'h00, 1'b0); idle_check(1);

        // Back-to-back with start held and noise during RUN
        op(8'h10, 8'h20, 1'b1);
        op(8'h33, 8'h33, 1'b1);
        idle_check(2);

        // Reset two cycles into RUN aborts the operation
        start = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_eq", 32'(eq), 32'd0);
        chk("abort_lt", 32'(lt), 32'd0);
        prev_eq = 1'b0;
        prev_lt = 1'b0;
        idle_check(6);
        op(8'hC3, 8'hC3, 1'b0); idle_check(1);

        // Random operations, mixing back-to-back and idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (($urandom % 4) == 0) ? ra : 8'($urandom);
            op(ra, rb, 1'($urandom));
            if ($urandom % 2) idle_check(1 + ($urandom % 3));
        end
        idle_check(1);

        // S=2 instance
        op2(2'b01, 2'b10);
        for (int n = 0; n < 8; n++) op2(2'($urandom), 2'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
